wb_rr_arbiter: RTL and testbench

Parametrised N-master to one-slave Wishbone B4 (classic cycle) arbiter with round-robin fairness, byte selects and error return. It sits between the core's bus masters (fetch, load/store, debug/DMA) and the shared memory/peripheral bus, generalising the fixed 32-bit single-master WB4 link to configurable widths and master count. An optional watchdog terminates slave cycles that never acknowledge.

---
 rtl/wb_rr_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter -- N-master to one-slave Wishbone B4 classic arbiter.
//
// Round-robin grant among masters raising CYC; the winner keeps the bus for
// its whole CYC (bursts / RMW), then the pointer moves to the next index.
// Slave ACK/ERR are routed combinationally to the owner; ERR beats ACK.
//
// Optional build macro: WB_ARB_TIMEOUT_EN -- adds a watchdog that errors out
// a strobe the slave has not answered within TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   m_cyc/stb/we      per-master controls              [N_MASTERS]
//   m_adr/sel/dat_w   packed per-master request fields
//   m_dat_r           slave read data broadcast to all masters
//   m_ack/m_err       per-master responses (owner only)
//   s_*               slave-side bus
//   gnt, busy         current owner index, bus-owned flag

module wb_rr_arb_lane #(
  parameter int GW   = 2,
  parameter int LANE = 0
) (
  input  logic          busy,
  input  logic [GW-1:0] gnt,
  input  logic          ack_bit,
  input  logic          err_bit,
  output logic          ack,
  output logic          err
);
  logic own;
  assign own = busy & (gnt == GW'(LANE));
  assign ack = own & ack_bit;
  assign err = own & err_bit;
endmodule

module wb_rr_arbiter #(
  parameter  int N_MASTERS      = 4,
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = DATA_W / 8,
  localparam int GW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [N_MASTERS*SEL_W-1:0]    m_sel,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_w,
  output logic [DATA_W-1:0]             m_dat_r,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [SEL_W-1:0]              s_sel,
  output logic [DATA_W-1:0]             s_dat_w,
  input  logic [DATA_W-1:0]             s_dat_r,
  input  logic                          s_ack,
  input  logic                          s_err,
  output logic [GW-1:0]                 gnt,
  output logic                          busy
);

  if (N_MASTERS < 2 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("wb_rr_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] ptr_q, ptr_d;

  // Unpacked views of the packed request buses.
  logic [N_MASTERS-1:0][ADDR_W-1:0] adr_a;
  logic [N_MASTERS-1:0][SEL_W-1:0]  sel_a;
  logic [N_MASTERS-1:0][DATA_W-1:0] dat_a;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign adr_a[i] = m_adr[i*ADDR_W +: ADDR_W];
    assign sel_a[i] = m_sel[i*SEL_W  +: SEL_W];
    assign dat_a[i] = m_dat_w[i*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to ptr (offset 0) is the last to overwrite and wins.
  logic          pick_vld;
  logic [GW-1:0] pick;
  logic [GW:0]   idx;

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(N_MASTERS)) idx = idx - (GW+1)'(N_MASTERS);
      if (m_cyc[idx[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWNED;
          gnt_d   = pick;
        end
      end
      OWNED: begin
        if (!m_cyc[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == GW'(N_MASTERS - 1)) ? '0 : gnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q == OWNED);
  assign gnt  = gnt_q;

  // Slave-side mux on the registered grant; everything zero while idle.
  // STB is qualified by the owner's CYC so release drops both at once.
  logic s_stb_raw;
  logic wd_fire;

  always_comb begin
    s_cyc     = 1'b0;
    s_stb_raw = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_sel     = '0;
    s_dat_w   = '0;
    if (busy) begin
      s_cyc     = m_cyc[gnt_q];
      s_stb_raw = m_cyc[gnt_q] & m_stb[gnt_q];
      s_we      = m_we[gnt_q];
      s_adr     = adr_a[gnt_q];
      s_sel     = sel_a[gnt_q];
      s_dat_w   = dat_a[gnt_q];
    end
  end

  assign s_stb = s_stb_raw & ~wd_fire;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 16) ? $clog2(TIMEOUT_CYCLES) + 1 : 16;

  logic [CNT_W-1:0] wd_cnt;

  // Fires in the TIMEOUT_CYCLES-th unanswered strobe cycle; that cycle the
  // strobe is withdrawn from the slave and the owner sees ERR instead.
  assign wd_fire = s_stb_raw & ~s_ack & ~s_err & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             wd_cnt <= '0;
    else if (!s_stb_raw || s_ack || s_err || wd_fire)     wd_cnt <= '0;
    else                                                  wd_cnt <= wd_cnt + CNT_W'(1);
  end
`else
  assign wd_fire = 1'b0;
`endif

  // ERR has priority: a beat answered with both reports only the error.
  logic ack_bit, err_bit;
  assign ack_bit = s_ack & s_stb & ~s_err;
  assign err_bit = (s_err & s_stb) | wd_fire;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    wb_rr_arb_lane #(.GW(GW), .LANE(i)) u_lane (
      .busy    (busy),
      .gnt     (gnt_q),
      .ack_bit (ack_bit),
      .err_bit (err_bit),
      .ack     (m_ack[i]),
      .err     (m_err[i])
    );
  end

  // Read data is a straight broadcast, forced to zero while reset is held.
  assign m_dat_r = rst ? s_dat_r : '0;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*AW-1:0]   m_adr;
  logic [N*SW-1:0]   m_sel;
  logic [N*DW-1:0]   m_dat_w;
  logic [DW-1:0]     m_dat_r;
  logic [N-1:0]      m_ack, m_err;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_w;
  logic [DW-1:0]     s_dat_r;
  logic              s_ack, s_err;
  logic [GW-1:0]     gnt;
  logic              busy;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Response vectors applied while master 2 owns the bus.
  typedef struct {
    string      nm;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic       exp_stb;
    logic [3:0] exp_ack;
    logic [3:0] exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"v_wait",      4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
    tbl[1] = '{"v_ack",       4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000};
    tbl[2] = '{"v_err",       4'b0100, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100};
    tbl[3] = '{"v_ack_err",   4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100};
    tbl[4] = '{"v_nostb",     4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[5] = '{"v_other_stb", 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};

    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = 32'h1000 * (i + 1);
      m_sel[i*SW +: SW]   = 4'h3;
      m_dat_w[i*DW +: DW] = 32'hA0 + i;
    end
    m_sel[2*SW +: SW] = 4'hF;

    // Reset state, with a request pending that must not be granted.
    m_cyc = 4'b0001;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_scyc", s_cyc, 0);
    tick();
    chk("rst_hold_busy", busy, 0);
    m_cyc = '0;
    rst = 1'b1;

    // Grant latency and asynchronous reset mid-cycle.
    m_cyc = 4'b0010; m_stb = 4'b0010;
    #1;
    chk("lat_c0_busy", busy, 0);
    tick();
    chk("lat_c1_gnt", gnt, 1);
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_scyc", s_cyc, 1);
    chk("lat_c1_sstb", s_stb, 1);
    chk("lat_c1_sadr", s_adr, 32'h2000);
    chk("lat_c1_sdatw", s_dat_w, 32'hA1);
    rst = 1'b0;
    #1;
    chk("arst_scyc", s_cyc, 0);
    chk("arst_sstb", s_stb, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_sadr", s_adr, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_gnt", gnt, 1);
    chk("post_rst_busy", busy, 1);
    m_cyc = '0; m_stb = '0;
    #1;
    chk("rel_scyc", s_cyc, 0);
    tick();
    chk("rel_idle", busy, 0);

    // Single read by master 2, three wait cycles.
    m_adr[2*AW +: AW] = 32'h100;
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0000;
    tick();
    chk("rd_gnt", gnt, 2);
    chk("rd_sadr", s_adr, 32'h100);
    chk("rd_ssel", s_sel, 4'hF);
    chk("rd_swe", s_we, 0);
    for (int c = 0; c < 3; c++) begin
      chk("rd_wait_ack", m_ack, 0);
      tick();
    end
    s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
    #1;
    chk("rd_ack", m_ack, 4'b0100);
    chk("rd_dat", m_dat_r, 32'hDEADBEEF);
    tick();
    s_ack = 1'b0;
    #1;
    chk("rd_ack_drop", m_ack, 0);

    // Response routing table.
    for (int i = 0; i < 6; i++) begin
      m_stb = tbl[i].stb; s_ack = tbl[i].ack; s_err = tbl[i].err;
      #1;
      chk({tbl[i].nm, "_sstb"}, s_stb, tbl[i].exp_stb);
      chk({tbl[i].nm, "_ack"}, m_ack, tbl[i].exp_ack);
      chk({tbl[i].nm, "_err"}, m_err, tbl[i].exp_err);
      tick();
    end
    s_ack = 1'b0; s_err = 1'b0;
    m_cyc = '0; m_stb = '0;
    tick();

    // Round robin with all masters requesting, from a fresh pointer.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_cyc = 4'b1111; m_stb = 4'b1111;
    tick();
    for (int r = 0; r < 5; r++) begin
      int e;
      e = r % N;
      chk("rr_gnt", gnt, e);
      chk("rr_busy", busy, 1);
      s_ack = 1'b1;
      #1;
      chk("rr_ack", m_ack, 4'b0001 << e);
      tick();
      s_ack = 1'b0;
      m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
      #1;
      chk("rr_rel_scyc", s_cyc, 0);
      tick();
      chk("rr_dead", busy, 0);
      m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
      tick();
    end
    m_cyc = '0; m_stb = '0;
    tick();

    // Lock: master 0 bursts while master 3 waits.
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick();
    m_cyc = 4'b1001; m_stb = 4'b1001;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      #1;
      chk("lock_gnt", gnt, 0);
      chk("lock_ack", m_ack, 4'b0001);
      tick();
    end
    s_ack = 1'b0;
    m_cyc = 4'b1000; m_stb = 4'b1000;
    #1;
    chk("lock_rel_scyc", s_cyc, 0);
    tick();
    chk("lock_dead", busy, 0);
    tick();
    chk("lock_next_gnt", gnt, 3);
    chk("lock_next_scyc", s_cyc, 1);
    m_cyc = '0; m_stb = '0;
    tick();

    // Non-responding slave.
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      chk("wd_pre_sstb", s_stb, 1);
      chk("wd_pre_err", m_err, 0);
      tick();
    end
    chk("wd_err", m_err, 4'b0010);
    chk("wd_sstb", s_stb, 0);
`else
    repeat (100) tick();
    chk("stall_sstb", s_stb, 1);
    chk("stall_err", m_err, 0);
`endif
    m_cyc = '0; m_stb = '0;
    tick();
    chk("end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
